// File: rtl/voice_mixer_pkg.sv
// Shared constants and types for the voice mixer.
package voice_mixer_pkg;

  localparam int unsigned N_OSCILLATORS   = 8;
  localparam int unsigned SAMPLE_WIDTH    = 24;
  localparam int unsigned MIXER_VOL_WIDTH = 9;
  localparam int unsigned MIXER_VOL_UNITY = 1 << (MIXER_VOL_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    OUT
  } mixer_state_t;

  // Accumulator width that holds the sum of n full-scale w-bit samples.
  function automatic int unsigned mixer_acc_width(input int unsigned w, input int unsigned n);
    return (n <= 1) ? w : w + $clog2(n);
  endfunction

endpackage

// File: rtl/voice_mixer_sat_clamp.sv
// Signed saturating width reduction: IN_W -> OUT_W, with a clip flag.
// IN_W must be strictly greater than OUT_W.
module sat_clamp #(
  parameter int unsigned IN_W  = 34,
  parameter int unsigned OUT_W = 24
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o,
  output logic             clipped_o
);

  logic [IN_W-OUT_W:0] upper;

  // Value fits when the bits above the output sign bit are a pure sign extension.
  always_comb begin
    upper     = in_i[IN_W-1:OUT_W-1];
    clipped_o = !((&upper) || !(|upper));
    out_o     = in_i[OUT_W-1:0];
    if (clipped_o) begin
      out_o = in_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// Voice mixer: sums one signed sample per voice per sample tick, applies
// master volume (capped at unity), reduces to WIDTH and strobes out_valid.
// Optional feature macro: MIXER_SATURATE_EN (saturate instead of wrap).
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int unsigned WIDTH     = SAMPLE_WIDTH,
  parameter int unsigned N_VOICES  = N_OSCILLATORS,
  parameter int unsigned VOL_WIDTH = MIXER_VOL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic [WIDTH-1:0]     voice_data [N_VOICES],
  input  logic [VOL_WIDTH-1:0] volume,
  output logic [WIDTH-1:0]     out_sample,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 clip,
  output logic                 overrun
);

  localparam int unsigned ACC_W  = mixer_acc_width(WIDTH, N_VOICES);
  localparam int unsigned PROD_W = ACC_W + VOL_WIDTH + 1;
  localparam int unsigned IDX_W  = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_VOICES - 1);
  localparam logic [VOL_WIDTH-1:0] VOL_UNITY = {1'b1, {(VOL_WIDTH-1){1'b0}}};

  mixer_state_t               state_q;
  logic [WIDTH-1:0]           snap_q [N_VOICES];
  logic [VOL_WIDTH-1:0]       vol_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic [IDX_W-1:0]           idx_q;
  logic [WIDTH-1:0]           out_sample_q;
  logic                       out_valid_q;
  logic                       clip_q;
  logic                       overrun_q;

  logic [VOL_WIDTH-1:0]       gain;
  logic signed [PROD_W-1:0]   acc_ext;
  logic signed [PROD_W-1:0]   gain_ext;
  logic signed [PROD_W-1:0]   product;
  logic signed [PROD_W-1:0]   shifted;
  logic [WIDTH-1:0]           out_sample_d;
  logic                       clip_d;

  // Gain-scale the accumulated sum; gain is zero-extended so it stays positive.
  always_comb begin
    gain     = (vol_q > VOL_UNITY) ? VOL_UNITY : vol_q;
    acc_ext  = PROD_W'(acc_q);
    gain_ext = signed'(PROD_W'(gain));
    product  = acc_ext * gain_ext;
    shifted  = product >>> (VOL_WIDTH - 1);
  end

`ifdef MIXER_SATURATE_EN
  sat_clamp #(
    .IN_W  (PROD_W),
    .OUT_W (WIDTH)
  ) u_sat_clamp (
    .in_i      (shifted),
    .out_o     (out_sample_d),
    .clipped_o (clip_d)
  );
`else
  logic unused_hi;

  // Two's-complement wrap: keep the low WIDTH bits, never flag a clip.
  always_comb begin
    out_sample_d = shifted[WIDTH-1:0];
    clip_d       = 1'b0;
    unused_hi    = ^shifted[PROD_W-1:WIDTH];
  end
`endif

  // Mix sequencer: snapshot on tick, accumulate one voice per cycle, scale, strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      for (int unsigned i = 0; i < N_VOICES; i++) begin
        snap_q[i] <= '0;
      end
      vol_q        <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      clip_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (sample_tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            for (int unsigned i = 0; i < N_VOICES; i++) begin
              snap_q[i] <= voice_data[i];
            end
            vol_q   <= volume;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_q + ACC_W'(signed'(snap_q[idx_q]));
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= SCALE;
          end
        end
        SCALE: begin
          out_sample_q <= out_sample_d;
          clip_q       <= clip_d;
          out_valid_q  <= 1'b1;
          state_q      <= OUT;
        end
        OUT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != IDLE);
  assign clip       = clip_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer (N_VOICES=8, WIDTH=24, VOL_WIDTH=9).
module tb_voice_mixer;
  import voice_mixer_pkg::*;

  localparam int NV = 8;
  localparam int W  = 24;
  localparam int VW = 9;
  localparam longint SMAX = 64'sd8388607;
  localparam longint SMIN = -64'sd8388608;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_tick;
  logic [W-1:0]  vd [NV];
  logic [VW-1:0] volume;
  logic [W-1:0]  out_sample;
  logic          out_valid;
  logic          busy;
  logic          clip;
  logic          overrun;

  voice_mixer #(
    .WIDTH     (W),
    .N_VOICES  (NV),
    .VOL_WIDTH (VW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .voice_data  (vd),
    .volume      (volume),
    .out_sample  (out_sample),
    .out_valid   (out_valid),
    .busy        (busy),
    .clip        (clip),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint      smp;
    longint      clp;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference mix of the inputs currently driven.
  task automatic push_exp();
    longint s = 0;
    longint g;
    longint r;
    logic [63:0] rv;
    exp_t e;
    for (int i = 0; i < NV; i++) s += longint'($signed(vd[i]));
    g = (volume > 256) ? 256 : longint'(volume);
    r = (s * g) >>> 8;
`ifdef MIXER_SATURATE_EN
    if (r > SMAX) begin e.smp = SMAX; e.clp = 1; end
    else if (r < SMIN) begin e.smp = SMIN; e.clp = 1; end
    else begin e.smp = r; e.clp = 0; end
`else
    rv    = r;
    e.smp = longint'($signed(rv[W-1:0]));
    e.clp = 0;
`endif
    e.at = cyc + NV + 2;
    sb.push_back(e);
  endtask

  task automatic tick(input bit expect_out);
    if (expect_out) push_exp();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic set_all(input longint v);
    for (int i = 0; i < NV; i++) vd[i] = W'(v);
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NV; i++) vd[i] = W'($urandom);
    volume = VW'($urandom);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
  endtask

  task automatic mix(input longint v0, input longint rest, input int vol);
    set_all(rest);
    vd[0]  = W'(v0);
    volume = VW'(vol);
    tick(1'b1);
    wait_drain();
  endtask

  // Output monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexp_valid", out_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("sample", longint'($signed(out_sample)), mon_e.smp);
        check("clip", clip, mon_e.clp);
        check("latency", cyc, mon_e.at);
      end
    end
  end

  initial begin
    rst = 1'b1;
    sample_tick = 1'b0;
    set_all(0);
    volume = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", out_sample, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_clip", clip, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Unity gain with busy/valid framing checked cycle by cycle.
    set_all(0); vd[0] = W'(1000); volume = 9'd256;
    tick(1'b1);
    check("busy_c1", busy, 1);
    repeat (9) @(posedge clk);
    #1;
    check("busy_c10", busy, 1);
    check("valid_c10", out_valid, 1);
    @(posedge clk); #1;
    check("busy_c11", busy, 0);
    check("valid_c11", out_valid, 0);
    wait_drain();

    mix(1000, 0, 128);
    mix(1000, 0, 511);
    mix(-1000, -1000, 256);
    mix(-3, 0, 128);
    mix(8388607, 8388607, 256);
    mix(-8388608, -8388608, 300);
    mix(12345, -777, 0);

    // Inputs change every cycle after capture; result must reflect the snapshot.
    randomize_inputs();
    tick(1'b1);
    for (int i = 0; i < 10; i++) begin
      randomize_inputs();
      @(posedge clk); #1;
    end
    wait_drain();

    // Tick in cycle 4 is dropped and latches overrun.
    set_all(200); volume = 9'd256;
    tick(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("ovr_before", overrun, 0);
    set_all(-5000);
    tick(1'b0);
    check("ovr_set", overrun, 1);
    wait_drain();
    mix(7, 7, 256);
    check("ovr_sticky", overrun, 1);

    // Reset in cycle 5 abandons the mix.
    set_all(4444); volume = 9'd256;
    tick(1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_sample", out_sample, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_clip", clip, 0);
    check("mrst_overrun", overrun, 0);
    repeat (8) @(posedge clk);
    #1;
    mix(-250, 31, 256);

    // Tick coincident with reset is ignored.
    rst = 1'b1; sample_tick = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; sample_tick = 1'b0;
    check("rsttick_busy", busy, 0);
    repeat (12) @(posedge clk);
    #1;
    check("rsttick_overrun", overrun, 0);

    // Back-to-back random mixes at the fastest accepted rate.
    for (int k = 0; k < 6; k++) begin
      randomize_inputs();
      tick(1'b1);
      repeat (NV + 2) @(posedge clk);
      #1;
    end
    wait_drain();
    check("final_overrun", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
